// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: control inputs, instruction memory port, IR issue handshake and status.
// The sequencer uses master; the memory/decoder/execute environment uses slave.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              start;
    logic              halt;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_instr;
    logic              IR_enable;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              running;
    logic [7:0]        fetch_count;

    modport master (
        input  start, halt, imem_instr, ir_ready, redirect_valid, redirect_target,
        output imem_addr, IR_enable, ir, ir_pc, ir_valid, running, fetch_count
    );

    modport slave (
        output start, halt, imem_instr, ir_ready, redirect_valid, redirect_target,
        input  imem_addr, IR_enable, ir, ir_pc, ir_valid, running, fetch_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Steps the PC through instruction memory, latches each word into ir and issues it over valid/ready.
// start -> ir_valid two cycles later; ir is held while ir_ready is low; one issue per two cycles peak.
module fetch_sequencer #(
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              ir_valid_q, ir_valid_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              handshake;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            cnt_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        cnt_d      = cnt_q;
        handshake  = ir_valid_q & bus.ir_ready;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pc_d    = RESET_PC;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (bus.redirect_valid) begin
                    pc_d = bus.redirect_target;
                end else if (bus.halt) begin
                    state_d = IDLE;
                end else begin
                    ir_d       = bus.imem_instr;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // An instruction accepted in the redirect cycle still counts as issued.
                if (handshake && cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (bus.redirect_valid) begin
                    ir_valid_d = 1'b0;
                    pc_d       = bus.redirect_target;
                    state_d    = FETCH;
                end else if (handshake) begin
                    ir_valid_d = 1'b0;
                    pc_d       = pc_q + ADDR_W'(1);
                    state_d    = bus.halt ? IDLE : FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.imem_addr   = pc_q;
    assign bus.IR_enable   = (state_q == FETCH);
    assign bus.ir          = ir_q;
    assign bus.ir_pc       = ir_pc_q;
    assign bus.ir_valid    = ir_valid_q;
    assign bus.running     = (state_q != IDLE);
    assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed cycle table, wrap/saturation/reset sequences, then random traffic vs a PC-level model.
module tb_fetch_sequencer;
    logic clk;
    logic reset;
    logic [15:0] mem [16];

    fetch_sequencer_if #(.ADDR_W(4), .DATA_W(16)) bus ();

    fetch_sequencer #(.ADDR_W(4), .DATA_W(16), .RESET_PC(4'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    assign bus.imem_instr = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic hl, input logic rdy, input logic rv, input logic [3:0] tgt);
        bus.start           = st;
        bus.halt            = hl;
        bus.ir_ready        = rdy;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " vld"},  32'(bus.ir_valid),    0);
        check({tag, " en"},   32'(bus.IR_enable),   0);
        check({tag, " run"},  32'(bus.running),     0);
        check({tag, " addr"}, 32'(bus.imem_addr),   0);
        check({tag, " ir"},   32'(bus.ir),          0);
        check({tag, " irpc"}, 32'(bus.ir_pc),       0);
        check({tag, " cnt"},  32'(bus.fetch_count), 0);
    endtask

    // One row per cycle: inputs applied that cycle and the outputs expected in it.
    typedef struct {
        int st, hl, rdy, rv, tgt;
        int en, vld, irpc, addr, run, cnt;
    } vec_t;

    vec_t tbl[19];

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] seen [$];
        logic [3:0] exp_pc;
        logic [3:0] prev_pc;
        logic [15:0] prev_ir;
        logic       prev_hold;
        logic       hs;
        int         issued;
        int         stall;
        int         got;

        //            st hl rd rv tgt  en vl pc ad rn cnt
        tbl[0]  = '{1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 0,   1, 0, 0, 0, 1, 0};
        tbl[2]  = '{0, 0, 1, 0, 0,   0, 1, 0, 0, 1, 0};
        tbl[3]  = '{0, 0, 1, 0, 0,   1, 0, 0, 1, 1, 1};
        tbl[4]  = '{0, 0, 0, 0, 0,   0, 1, 1, 1, 1, 1};
        tbl[5]  = '{0, 1, 0, 0, 0,   0, 1, 1, 1, 1, 1};
        tbl[6]  = '{0, 1, 1, 0, 0,   0, 1, 1, 1, 1, 1};
        tbl[7]  = '{0, 0, 0, 1, 9,   0, 0, 1, 2, 0, 2};
        tbl[8]  = '{1, 0, 0, 0, 0,   0, 0, 1, 2, 0, 2};
        tbl[9]  = '{0, 0, 0, 1, 5,   1, 0, 1, 0, 1, 2};
        tbl[10] = '{0, 0, 0, 0, 0,   1, 0, 1, 5, 1, 2};
        tbl[11] = '{0, 0, 1, 1, 14,  0, 1, 5, 5, 1, 2};
        tbl[12] = '{0, 0, 1, 0, 0,   1, 0, 5, 14, 1, 3};
        tbl[13] = '{0, 0, 0, 1, 3,   0, 1, 14, 14, 1, 3};
        tbl[14] = '{0, 0, 1, 0, 0,   1, 0, 14, 3, 1, 3};
        tbl[15] = '{0, 1, 1, 0, 0,   0, 1, 3, 3, 1, 3};
        tbl[16] = '{1, 0, 0, 0, 0,   0, 0, 3, 4, 0, 4};
        tbl[17] = '{0, 1, 0, 0, 0,   1, 0, 3, 0, 1, 4};
        tbl[18] = '{0, 0, 0, 0, 0,   0, 0, 3, 0, 0, 4};

        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        reset = 1'b1;
        drive(0, 0, 0, 0, 4'h0);
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(tbl[i].st != 0, tbl[i].hl != 0, tbl[i].rdy != 0, tbl[i].rv != 0, 4'(tbl[i].tgt));
            #1;
            check($sformatf("row%0d en", i),   32'(bus.IR_enable),   tbl[i].en);
            check($sformatf("row%0d vld", i),  32'(bus.ir_valid),    tbl[i].vld);
            check($sformatf("row%0d irpc", i), 32'(bus.ir_pc),       tbl[i].irpc);
            check($sformatf("row%0d addr", i), 32'(bus.imem_addr),   tbl[i].addr);
            check($sformatf("row%0d run", i),  32'(bus.running),     tbl[i].run);
            check($sformatf("row%0d cnt", i),  32'(bus.fetch_count), tbl[i].cnt);
            if (tbl[i].vld != 0)
                check($sformatf("row%0d ir", i), 32'(bus.ir), 32'(mem[4'(tbl[i].irpc)]));
        end

        // Wrap: redirect to 14 and free-run with ir_ready held high.
        @(negedge clk); drive(1, 0, 0, 0, 4'h0);
        @(negedge clk); drive(0, 0, 0, 1, 4'd14);
        @(negedge clk); drive(0, 0, 1, 0, 4'h0);
        for (int c = 0; c < 40 && seen.size() < 4; c++) begin
            #1;
            if (bus.ir_valid && bus.ir_ready) begin
                seen.push_back(bus.ir_pc);
                check("wrap ir", 32'(bus.ir), 32'(mem[bus.ir_pc]));
            end
            @(negedge clk);
        end
        check("wrap issued", seen.size(), 4);
        while (seen.size() < 4) seen.push_back(4'hX);
        check("wrap pc0", 32'(seen[0]), 14);
        check("wrap pc1", 32'(seen[1]), 15);
        check("wrap pc2", 32'(seen[2]), 0);
        check("wrap pc3", 32'(seen[3]), 1);

        repeat (600) @(negedge clk);
        #1;
        check("saturate cnt", 32'(bus.fetch_count), 255);
        check("saturate run", 32'(bus.running), 1);

        // Reset while running discards the pending instruction.
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("midrst");
        reset = 1'b0;
        drive(0, 0, 0, 0, 4'h0);

        // Random traffic against a PC-level model.
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        @(negedge clk); drive(1, 0, 0, 0, 4'h0);
        @(negedge clk); drive(0, 0, 0, 0, 4'h0);
        exp_pc    = 4'h0;
        issued    = 0;
        stall     = 0;
        prev_hold = 1'b0;
        prev_pc   = 4'h0;
        prev_ir   = 16'h0;
        for (int c = 0; c < 2000; c++) begin
            drive(0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, 4'($urandom));
            #1;
            check("rnd cnt", 32'(bus.fetch_count), (issued > 255) ? 255 : issued);
            if (prev_hold) begin
                check("rnd hold vld", 32'(bus.ir_valid), 1);
                check("rnd hold en",  32'(bus.IR_enable), 0);
                check("rnd hold pc",  32'(bus.ir_pc), 32'(prev_pc));
                check("rnd hold ir",  32'(bus.ir), 32'(prev_ir));
            end
            hs = bus.ir_valid & bus.ir_ready;
            if (hs) begin
                check("rnd pc", 32'(bus.ir_pc), 32'(exp_pc));
                check("rnd ir", 32'(bus.ir), 32'(mem[exp_pc]));
                issued++;
                stall = 0;
            end else begin
                stall++;
            end
            prev_hold = bus.ir_valid & ~bus.ir_ready & ~bus.redirect_valid;
            prev_pc   = bus.ir_pc;
            prev_ir   = bus.ir;
            if (bus.redirect_valid) exp_pc = bus.redirect_target;
            else if (hs)            exp_pc = exp_pc + 4'd1;
            if (stall > 40) begin
                n_checks++;
                n_err++;
                $display("FAIL rnd liveness: got no issue for %0d cycles expected at most 40", stall);
                break;
            end
            @(negedge clk);
        end
        check("rnd issued some", 32'(issued > 100), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
